// File: rtl/core_sequencer.sv
// core_sequencer: mission controller for the line-following delivery car.
// Debounces the hall sensor to detect load and unload. It latches the colour
// of the loaded object and tracks until a station of that colour is seen.
// It then buzzes, waits for unload and counts the delivery. It gives up after
// MAX_UTURNS U-turns.
//
// Optional feature macro: CORE_BUZZ_EXT_EN
//   When defined, the buzz_finished port exists and BUZZ waits for it. The
//   internal buzz timer is removed, and FAIL holds en_buzz steadily high.
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous active-high reset
//   hall                raw hall sensor (1 = object loaded), asynchronous
//   object_color_id     colour class of the loaded object
//   station_color_id    colour class of the current station
//   station_color_valid 1-cycle strobe qualifying station_color_id
//   end_of_track        level, tracking block reached track end
//   uturn_finished      1-cycle strobe from the U-turn block
//   buzz_finished       external buzz done (CORE_BUZZ_EXT_EN only)
//   en_tracking         enable line tracking
//   en_uturn            enable U-turn manoeuvre
//   en_buzz             buzzer on
//   ssd_code            {state code, latched colour, delivered count}
//   state_o             current state encoding (debug)
module core_sequencer #(
    parameter int unsigned COLOR_W      = 2,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned BUZZ_CYC     = 25000000,
    parameter int unsigned MAX_UTURNS   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hall,
    input  logic [COLOR_W-1:0] object_color_id,
    input  logic [COLOR_W-1:0] station_color_id,
    input  logic               station_color_valid,
    input  logic               end_of_track,
    input  logic               uturn_finished,
`ifdef CORE_BUZZ_EXT_EN
    input  logic               buzz_finished,
`endif
    output logic               en_tracking,
    output logic               en_uturn,
    output logic               en_buzz,
    output logic [15:0]        ssd_code,
    output logic [2:0]         state_o
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned UT_W  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRACK  = 3'd1,
        S_BUZZ   = 3'd2,
        S_WAIT   = 3'd3,
        S_UTURN  = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    // Hall synchroniser and debounce
    logic [1:0]      hall_sync;
    logic [DB_W-1:0] db_cnt;
    logic            hall_db;
    logic            hall_db_q;
    logic            load_evt;
    logic            unload_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hall_sync <= '0;
            db_cnt    <= '0;
            hall_db   <= 1'b0;
            hall_db_q <= 1'b0;
        end else begin
            hall_sync <= {hall_sync[0], hall};
            hall_db_q <= hall_db;
            if (hall_sync[1] == hall_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                // Synchronised value has differed for DEBOUNCE_CYC cycles
                hall_db <= hall_sync[1];
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign load_evt   =  hall_db & ~hall_db_q;
    assign unload_evt = ~hall_db &  hall_db_q;

    // FSM and datapath state
    state_t             state;
    state_t             state_n;
    logic [COLOR_W-1:0] obj_col;
    logic [COLOR_W-1:0] obj_col_n;
    logic [UT_W-1:0]    uturn_cnt;
    logic [UT_W-1:0]    uturn_cnt_n;
    logic [CNT_W-1:0]   deliv_cnt;
    logic [CNT_W-1:0]   deliv_cnt_n;

    logic               en_tracking_n;
    logic               en_uturn_n;
    logic               en_buzz_n;
    logic [15:0]        ssd_code_n;

`ifndef CORE_BUZZ_EXT_EN
    localparam int unsigned TM_W = (BUZZ_CYC > 1) ? $clog2(BUZZ_CYC) : 1;
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(BUZZ_CYC - 1);

    logic [TM_W-1:0] timer;
    logic [TM_W-1:0] timer_n;
    logic            timer_last;

    assign timer_last = (timer == TM_LAST);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_n     = state;
        obj_col_n   = obj_col;
        uturn_cnt_n = uturn_cnt;
        deliv_cnt_n = deliv_cnt;
        case (state)
            S_IDLE: begin
                if (load_evt) begin
                    obj_col_n   = object_color_id;
                    uturn_cnt_n = '0;
                    state_n     = S_TRACK;
                end
            end
            S_TRACK: begin
                if (unload_evt) begin
                    state_n = S_IDLE;
                end else if (station_color_valid && (station_color_id == obj_col)) begin
                    state_n = S_BUZZ;
                end else if (end_of_track) begin
                    state_n = S_UTURN;
                end
            end
            S_BUZZ: begin
`ifdef CORE_BUZZ_EXT_EN
                if (buzz_finished) begin
                    state_n = S_WAIT;
                end
`else
                if (timer_last) begin
                    state_n = S_WAIT;
                end
`endif
            end
            S_WAIT: begin
                if (unload_evt) begin
                    deliv_cnt_n = deliv_cnt + CNT_W'(1);
                    state_n     = S_IDLE;
                end
            end
            S_UTURN: begin
                if (uturn_finished) begin
                    uturn_cnt_n = uturn_cnt + UT_W'(1);
                    state_n     = (uturn_cnt_n == UT_W'(MAX_UTURNS)) ? S_FAIL : S_TRACK;
                end
            end
            S_FAIL: begin
                if (unload_evt) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

`ifndef CORE_BUZZ_EXT_EN
    // Shared BUZZ/FAIL timer: restarts on every state entry, wraps each BUZZ_CYC
    always_comb begin
        timer_n = '0;
        if ((state_n == state) && ((state == S_BUZZ) || (state == S_FAIL))) begin
            timer_n = timer_last ? '0 : (timer + TM_W'(1));
        end
    end
`endif

    // Moore outputs, evaluated on the next state so they register with it
    always_comb begin
        en_tracking_n = 1'b0;
        en_uturn_n    = 1'b0;
        en_buzz_n     = 1'b0;
        case (state_n)
            S_TRACK: en_tracking_n = 1'b1;
            S_UTURN: en_uturn_n    = 1'b1;
            S_BUZZ:  en_buzz_n     = 1'b1;
            S_FAIL: begin
`ifdef CORE_BUZZ_EXT_EN
                en_buzz_n = 1'b1;
`else
                // Alarm starts on, then flips every BUZZ_CYC cycles
                if (state != S_FAIL) begin
                    en_buzz_n = 1'b1;
                end else if (timer_last) begin
                    en_buzz_n = ~en_buzz;
                end else begin
                    en_buzz_n = en_buzz;
                end
`endif
            end
            default: begin
                en_buzz_n = 1'b0;
            end
        endcase
        ssd_code_n = {1'b0, state_n, 4'(obj_col_n), deliv_cnt_n};
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obj_col     <= '0;
            uturn_cnt   <= '0;
            deliv_cnt   <= '0;
            en_tracking <= 1'b0;
            en_uturn    <= 1'b0;
            en_buzz     <= 1'b0;
            ssd_code    <= '0;
        end else begin
            obj_col     <= obj_col_n;
            uturn_cnt   <= uturn_cnt_n;
            deliv_cnt   <= deliv_cnt_n;
            en_tracking <= en_tracking_n;
            en_uturn    <= en_uturn_n;
            en_buzz     <= en_buzz_n;
            ssd_code    <= ssd_code_n;
        end
    end

`ifndef CORE_BUZZ_EXT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else begin
            timer <= timer_n;
        end
    end
`endif

    assign state_o = state;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Parametrised mission controller for the line-following delivery car. It replaces the fixed-function core sequencer and sits between the sensor front-ends (hall, colour classifiers) and the actuator blocks (tracking, U-turn, buzzer, seven-segment driver).
- Latches the colour of a loaded object and tracks until a station of matching colour is seen.
- Buzzes, waits for unload, then counts the delivery.
- Gives up after a configurable number of U-turns.

Parameters:
COLOR_W, 2, width of colour class IDs
DEBOUNCE_CYC, 50000, consecutive stable cycles required on synchronised hall (1 ms at 50 MHz)
BUZZ_CYC, 25000000, buzz duration in clk cycles (0.5 s), internal timer mode only
MAX_UTURNS, 3, U-turns allowed per delivery before FAIL; range 1..15

Ports:
clk  in  1  50 MHz system clock
rst  in  1  asynchronous active-high reset
hall  in  1  raw hall sensor, 1 = object loaded; asynchronous to clk
object_color_id  in  COLOR_W  colour class of loaded object
station_color_id  in  COLOR_W  colour class of current station
station_color_valid  in  1  1-cycle strobe: station_color_id is valid
end_of_track  in  1  level: tracking block reached track end
uturn_finished  in  1  1-cycle strobe from U-turn block
buzz_finished  in  1  present only with CORE_BUZZ_EXT_EN
en_tracking  out  1  enable line tracking
en_uturn  out  1  enable U-turn manoeuvre
en_buzz  out  1  buzzer on
ssd_code  out  16  display word: [15:12] state code, [11:8] latched colour (zero-extended), [7:0] delivered count
state_o  out  3  current state encoding, for debug

Behaviour:
- Hall path: 2-FF synchroniser, then debounce counter. hall_db takes the new value only after the synchronised value differs from hall_db for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count. Reset hall_db = 0.
- Debounce output is edge-detected into load_evt (rise) and unload_evt (fall).
- States and codes: IDLE = 0, TRACK = 1, BUZZ = 2, WAIT_UNLOAD = 3, UTURN = 4, FAIL = 5. Moore outputs are registered; every transition takes effect 1 cycle after the triggering event.
- IDLE:
  - All enables 0.
  - load_evt: latch object_color_id into obj_col, clear uturn_cnt, go to TRACK.
- TRACK:
  - en_tracking = 1.
  - station_color_valid with station_color_id == obj_col: go to BUZZ.
  - Otherwise, end_of_track = 1: go to UTURN.
  - unload_evt (object lost): go to IDLE, no count.
  - Priority: unload_evt > match > end_of_track.
- BUZZ:
  - en_buzz = 1, en_tracking = 0. Timer loads 0 on entry.
  - Leave for WAIT_UNLOAD when the timer reaches BUZZ_CYC-1, so en_buzz is high for exactly BUZZ_CYC cycles.
- WAIT_UNLOAD:
  - All enables 0.
  - unload_evt: deliv_cnt += 1 (8-bit, wraps 255 -> 0), go to IDLE.
- UTURN:
  - en_uturn = 1.
  - uturn_finished: uturn_cnt += 1. If the new uturn_cnt == MAX_UTURNS go to FAIL, else go to TRACK.
  - unload_evt is ignored here.
- FAIL:
  - en_buzz toggles every BUZZ_CYC cycles (alarm); other enables 0.
  - unload_evt: go to IDLE, deliv_cnt unchanged.
- Reset values: state IDLE, all enables 0, obj_col 0, uturn_cnt 0, deliv_cnt 0, timers 0, ssd_code 0x0000.
- Reset asserted mid-operation returns everything to its reset value within the assertion; no pending event survives reset.
- station_color_valid and uturn_finished outside their consuming states are ignored.
- end_of_track held high on re-entry to TRACK triggers another U-turn next cycle; the counted U-turn limit bounds this.

Optional Feature:
CORE_BUZZ_EXT_EN
- Defined:
  - Port buzz_finished exists; BUZZ exits to WAIT_UNLOAD on buzz_finished = 1 and the internal buzz timer is removed.
  - FAIL holds en_buzz = 1 steadily, with no toggle.
- Undefined: no buzz_finished port; timer behaviour as above.

Test Plan:
(Bench parameters: DEBOUNCE_CYC = 4, BUZZ_CYC = 10, MAX_UTURNS = 2.)
1. Load: hall high, object_color_id = 2 -> en_tracking rises 2 sync + 4 debounce + 1 cycles later; ssd_code = 0x1200.
2. Bounce: hall pulses high for 3 cycles, 5 times -> hall_db stays 0, state stays IDLE.
3. Delivery: in TRACK, strobe station 1 (ignored), then station 2 -> en_buzz high for exactly 10 cycles -> WAIT_UNLOAD; hall low -> IDLE, ssd_code[7:0] = 0x01.
4. U-turn limit: end_of_track then uturn_finished, twice -> second completion enters FAIL (state_o = 5); en_buzz toggles with period 20 cycles; unload -> IDLE, count unchanged.
5. Priority: match strobe and end_of_track in the same cycle -> BUZZ, not UTURN.
6. Reset and wrap: rst pulsed mid-BUZZ -> all outputs 0 immediately; after 256 deliveries ssd_code[7:0] wraps to 0x00.
